// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and record sizing for the output trace logger
// Record width grows by the timestamp when OUT_TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } ser_state_t;

  localparam int WORD_BYTES = 8;
  localparam int TS_BYTES   = 2;

`ifdef OUT_TRACE_TIMESTAMP_EN
  localparam int REC_BYTES = TS_BYTES + WORD_BYTES;
`else
  localparam int REC_BYTES = WORD_BYTES;
`endif

  localparam int REC_W = REC_BYTES * 8;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - record FIFO with full/empty/count; a push while full is ignored
// Read data is the current head entry, valid whenever empty is low.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/out_trace_logger.sv
// rtl/out_trace_logger.sv - captures program_out changes and streams them as MSB-first bytes
// OUT_TRACE_TIMESTAMP_EN prefixes each record with a 16-bit cycle stamp.
module out_trace_logger
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [63:0]              program_out,
  input  logic                     capture_en,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int BIW = $clog2(REC_BYTES);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(REC_BYTES - 1);

  ser_state_t       state, state_next;
  logic [63:0]      prev_word;
  logic             push_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             load;
  logic             shift;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;
  logic [REC_W-1:0] shreg;
  logic [BIW-1:0]   byte_idx;

  assign push_req = capture_en && (program_out != prev_word);

`ifdef OUT_TRACE_TIMESTAMP_EN
  logic [15:0] ts_count;

  always_ff @(posedge clk) begin
    if (reset) ts_count <= '0;
    else       ts_count <= ts_count + 16'd1;
  end

  assign rec_in = {ts_count, program_out};
`else
  assign rec_in = program_out;
`endif

  // Full is judged before this edge's pop, so a drop here is never rescued by a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_word <= '0;
      overflow  <= 1'b0;
    end else begin
      if (capture_en)            prev_word <= program_out;
      if (push_req && fifo_full) overflow  <= 1'b1;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (rec_in),
    .pop   (pop),
    .rdata (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    byte_valid = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_next = LOAD;
      LOAD: begin
        pop        = 1'b1;
        load       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          shift = 1'b1;
          if (byte_idx == LAST_IDX) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shifting in zeros leaves byte_data at 0 once a record is fully sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (load) begin
      shreg    <= rec_out;
      byte_idx <= '0;
    end else if (shift) begin
      shreg    <= {shreg[REC_W-9:0], 8'h00};
      byte_idx <= byte_idx + BIW'(1);
    end
  end

  assign byte_data = shreg[REC_W-1 -: 8];

endmodule

// File: tb/tb_out_trace_logger.sv
// tb/tb_out_trace_logger.sv - self-checking bench for out_trace_logger against a record-level model
module tb_out_trace_logger;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int OFS   = REC_BYTES - WORD_BYTES;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] program_out = '0;
  logic        capture_en = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  out_trace_logger #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .program_out (program_out),
    .capture_en  (capture_en),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: queued records, the record being sent (busy/loading), and received bytes.
  logic [79:0] mq[$];
  logic [79:0] cur;
  int          cur_idx = 0;
  bit          loading = 0;
  bit          sending = 0;
  bit          m_ovf = 0;
  logic [63:0] m_prev = '0;
  logic [15:0] m_ts = '0;
  bit          started = 0;
  logic [7:0]  rx[$];

  function automatic logic [7:0] rec_byte(input logic [79:0] r, input int k);
    return r[8*(REC_BYTES-1-k) +: 8];
  endfunction

  always @(posedge clk) begin
    bit          push_req;
    bit          was_full;
    logic [79:0] rec;
    if (reset) begin
      mq.delete();
      loading = 0;
      sending = 0;
      m_ovf   = 0;
      m_prev  = '0;
      m_ts    = '0;
      started = 1;
    end else begin
      if (byte_valid && byte_ready) rx.push_back(byte_data);
      push_req = capture_en && (program_out != m_prev);
      was_full = (mq.size() == DEPTH);
`ifdef OUT_TRACE_TIMESTAMP_EN
      rec = {m_ts, program_out};
`else
      rec = {16'h0, program_out};
`endif
      if (sending) begin
        if (byte_ready) begin
          cur_idx++;
          if (cur_idx == REC_BYTES) sending = 0;
        end
      end else if (loading) begin
        cur     = mq.pop_front();
        cur_idx = 0;
        loading = 0;
        sending = 1;
      end else if (mq.size() > 0) begin
        loading = 1;
      end
      if (push_req) begin
        if (was_full) m_ovf = 1;
        else          mq.push_back(rec);
      end
      if (capture_en) m_prev = program_out;
      m_ts++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("valid", byte_valid, sending);
      if (sending) check("data", byte_data, rec_byte(cur, cur_idx));
      check("count", fifo_count, mq.size());
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic drain();
    bit idle = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && !loading && !sending) begin
        idle = 1;
        break;
      end
      step(1);
    end
    check("drain_done", idle, 1'b1);
  endtask

  initial begin
    logic [7:0] exp_a[8];
    logic [7:0] exp_b[8];
    bit         got3;
    exp_a = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    exp_b = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

    step(2);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_data", byte_data, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    check("rst_count", fifo_count, 0);

    // Single word, held constant: one record only.
    reset = 1'b0;
    rx.delete();
    byte_ready  = 1'b1;
    capture_en  = 1'b1;
    program_out = 64'h0123456789ABCDEF;
    step(25);
    drain();
    capture_en = 1'b0;
    check("single_len", rx.size(), REC_BYTES);
    for (int i = 0; i < 8; i++) check($sformatf("single_b%0d", i), rx[OFS+i], exp_a[i]);
    check("single_count", fifo_count, 0);
    check("single_ovf", overflow, 1'b0);

    // Overflow: serializer stalled on one record, then 9 more words into an 8-deep FIFO.
    pulse_reset();
    rx.delete();
    byte_ready  = 1'b0;
    capture_en  = 1'b1;
    program_out = 64'hAAAA000000000001;
    step(1);
    capture_en = 1'b0;
    step(4);
    capture_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      program_out = 64'h1000 + 64'(i);
      step(1);
    end
    capture_en = 1'b0;
    step(1);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1'b1);
    byte_ready = 1'b1;
    drain();
    check("ovf_len", rx.size(), 9 * REC_BYTES);
    check("ovf_last", rx[rx.size()-1], 8'h08);
    check("ovf_sticky", overflow, 1'b1);

    // Ready toggling mid-record.
    pulse_reset();
    rx.delete();
    capture_en  = 1'b1;
    program_out = 64'hFEDCBA9876543210;
    step(1);
    capture_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      byte_ready = (i % 2 == 0);
      step(1);
    end
    byte_ready = 1'b1;
    drain();
    check("toggle_len", rx.size(), REC_BYTES);
    for (int i = 0; i < 8; i++) check($sformatf("toggle_b%0d", i), rx[OFS+i], exp_b[i]);

    // Reset after the third byte aborts the record and empties the FIFO.
    pulse_reset();
    rx.delete();
    byte_ready = 1'b1;
    capture_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      program_out = 64'h5000 + 64'(i);
      step(1);
    end
    capture_en = 1'b0;
    got3 = 0;
    for (int i = 0; i < 50; i++) begin
      if (rx.size() >= 3) begin
        got3 = 1;
        break;
      end
      step(1);
    end
    check("abort_wait3", got3, 1'b1);
    reset = 1'b1;
    step(1);
    check("abort_valid", byte_valid, 1'b0);
    check("abort_count", fifo_count, 0);
    reset = 1'b0;
    rx.delete();
    step(20);
    check("abort_silent", rx.size(), 0);

    // Capture at cycle stamp 5 after reset.
    pulse_reset();
    rx.delete();
    step(5);
    capture_en  = 1'b1;
    program_out = 64'h1122334455667788;
    step(1);
    capture_en = 1'b0;
    drain();
`ifdef OUT_TRACE_TIMESTAMP_EN
    check("ts_hi", rx[0], 8'h00);
    check("ts_lo", rx[1], 8'h05);
`endif
    check("ts_word0", rx[OFS], 8'h11);
    check("ts_word7", rx[OFS+7], 8'h88);

    // Randomized traffic with stalls and overflow bursts.
    pulse_reset();
    for (int i = 0; i < 4000; i++) begin
      capture_en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) program_out = {$urandom(), 29'h0, 3'($urandom_range(0, 7))};
      if (i < 2000) byte_ready = ($urandom_range(0, 3) != 0);
      else          byte_ready = ($urandom_range(0, 7) == 0);
      step(1);
    end
    capture_en = 1'b0;
    byte_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
